// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   op_e       : arithmetic mode encoding presented on the op port
//   num_groups : number of lookahead groups for a given width/group size
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  function automatic int unsigned num_groups(input int unsigned width,
                                             input int unsigned group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead cell.
//   p, g : per-bit propagate / generate
//   cin  : carry into bit 0 of the group
//   c    : carry into each bit of the group (c[0] == cin)
//   pg   : group propagate (all bits propagate)
//   gg   : group generate (group produces a carry regardless of cin)
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic [GROUP-1:0] c,
  output logic             pg,
  output logic             gg
);

  // Flat lookahead: each carry is an OR of generate terms gated by the
  // propagates between them, plus cin gated by all lower propagates.
  always_comb begin : bit_carries
    logic acc;
    logic prop;
    c = '0;
    for (int i = 0; i < int'(GROUP); i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i] = acc | (prop & cin);
    end
  end

  // Group PG/GG, independent of cin.
  always_comb begin : group_terms
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    for (int j = int'(GROUP) - 1; j >= 0; j--) begin
      acc  = acc | (prop & g[j]);
      prop = prop & p[j];
    end
    gg = acc;
    pg = &p;
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready is combinational)
//   A, B, Cin, op         : operands, carry/borrow-in, mode (ADD/SUB/ADC/SBC)
//   out_valid / out_ready : result handshake
//   Sum, Cout, V, Z       : registered result and flags
// S1 forms per-bit and per-group P/G; S2 resolves carries and fills the
// output register.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int unsigned NG  = num_groups(WIDTH, GROUP);
  localparam int unsigned MSB = WIDTH - 1;

  if (((WIDTH % GROUP) != 0) || (WIDTH < GROUP)) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_adv, s1_adv;

  assign s2_adv   = out_ready || !out_valid_q;
  assign s1_adv   = s2_adv || !s1_valid_q;
  assign in_ready = s1_adv;

  // ---------------- stage 1: operand conditioning ----------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin : eff_operands
    b_eff   = B;
    cin_eff = 1'b0;
    case (op_e'(op))
      OP_ADD: begin b_eff = B;  cin_eff = 1'b0; end
      OP_SUB: begin b_eff = ~B; cin_eff = 1'b1; end
      OP_ADC: begin b_eff = B;  cin_eff = Cin;  end
      OP_SBC: begin b_eff = ~B; cin_eff = Cin;  end
      default: ;
    endcase
  end

  logic [WIDTH-1:0] p_in, g_in;
  logic [NG-1:0]    pg_in, gg_in;
  logic [WIDTH-1:0] s1_c_unused;

  assign p_in = A ^ b_eff;
  assign g_in = A & b_eff;

  // Only the group PG/GG outputs matter here; bit carries are resolved in S2.
  for (genvar k = 0; k < int'(NG); k++) begin : g_s1_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .p  (p_in[k*GROUP +: GROUP]),
      .g  (g_in[k*GROUP +: GROUP]),
      .cin(1'b0),
      .c  (s1_c_unused[k*GROUP +: GROUP]),
      .pg (pg_in[k]),
      .gg (gg_in[k])
    );
  end

  logic [WIDTH-1:0] s1_p_q, s1_p_d, s1_g_q, s1_g_d;
  logic [NG-1:0]    s1_pg_q, s1_pg_d, s1_gg_q, s1_gg_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_a_msb_q, s1_a_msb_d, s1_b_msb_q, s1_b_msb_d;

  always_comb begin : s1_next
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_pg_d    = s1_pg_q;
    s1_gg_d    = s1_gg_q;
    s1_cin_d   = s1_cin_q;
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_p_d     = p_in;
        s1_g_d     = g_in;
        s1_pg_d    = pg_in;
        s1_gg_d    = gg_in;
        s1_cin_d   = cin_eff;
        s1_a_msb_d = A[MSB];
        s1_b_msb_d = b_eff[MSB];
      end
    end
  end

  // ---------------- stage 2: carry resolution ----------------
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [NG-1:0]    s2_pg_unused, s2_gg_unused;
  logic [WIDTH-1:0] sum_c;
  logic             v_c;

  // Second-level lookahead: carry into group k from registered group terms.
  always_comb begin : group_carries
    logic acc;
    logic prop;
    grp_c = '0;
    for (int k = 0; k <= int'(NG); k++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prop & s1_gg_q[j]);
        prop = prop & s1_pg_q[j];
      end
      grp_c[k] = acc | (prop & s1_cin_q);
    end
  end

  for (genvar k = 0; k < int'(NG); k++) begin : g_s2_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .p  (s1_p_q[k*GROUP +: GROUP]),
      .g  (s1_g_q[k*GROUP +: GROUP]),
      .cin(grp_c[k]),
      .c  (bit_c[k*GROUP +: GROUP]),
      .pg (s2_pg_unused[k]),
      .gg (s2_gg_unused[k])
    );
  end

  assign sum_c = s1_p_q ^ bit_c;
  assign v_c   = (s1_a_msb_q == s1_b_msb_q) && (sum_c[MSB] != s1_a_msb_q);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, v_q, v_d, z_q, z_d;

  always_comb begin : out_next
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    v_d         = v_q;
    z_d         = z_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = sum_c;
        cout_d = grp_c[NG];
        v_d    = v_c;
        z_d    = ~|sum_c;
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin : regs
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_pg_q     <= '0;
      s1_gg_q     <= '0;
      s1_cin_q    <= 1'b0;
      s1_a_msb_q  <= 1'b0;
      s1_b_msb_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_pg_q     <= s1_pg_d;
      s1_gg_q     <= s1_gg_d;
      s1_cin_q    <= s1_cin_d;
      s1_a_msb_q  <= s1_a_msb_d;
      s1_b_msb_q  <= s1_b_msb_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      v_q         <= v_d;
      z_q         <= z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe at WIDTH=8, GROUP=4.
// Inputs change 1 time unit after the rising edge; handshakes and results
// are sampled on the falling edge.
module tb_cla_addsub_pipe;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, v, z;

  int n_checks = 0;
  int n_errors = 0;

  // expected {Sum, Cout, V, Z}
  logic [W+2:0] exp_q[$];

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (sum),
    .Cout     (cout),
    .V        (v),
    .Z        (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic ci);
    logic [W-1:0] yy;
    logic         c0;
    logic [W:0]   s;
    logic         ov;
    yy = o[0] ? ~y : y;
    c0 = o[1] ? ci : o[0];
    s  = {1'b0, x} + {1'b0, yy} + (W+1)'(c0);
    ov = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    return {s[W-1:0], s[W], ov, (s[W-1:0] == '0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic [W+2:0] e);
    logic acc;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    cin      = ci;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(e);
        done = 1'b1;
        break;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Result scoreboard: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check("result", 32'({sum, cout, v, z}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op        = 2'b00;
    out_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", 32'({cout, v, z}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD 0x0F + 0x01 with latency check
    send(2'b00, 8'h0F, 8'h01, 1'b0, {8'h10, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_sum", 32'(sum), 32'h10);
    tick();

    // directed vectors, back to back
    send(2'b10, 8'hFF, 8'hFF, 1'b0, {8'hFE, 1'b1, 1'b0, 1'b0});
    send(2'b10, 8'h55, 8'hAA, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
    send(2'b01, 8'h80, 8'h01, 1'b0, {8'h7F, 1'b1, 1'b1, 1'b0});
    send(2'b11, 8'h00, 8'h00, 1'b0, {8'hFF, 1'b0, 1'b0, 1'b0});
    send(2'b00, 8'h01, 8'h01, 1'b1, {8'h02, 1'b0, 1'b0, 1'b0});
    send(2'b01, 8'h05, 8'h05, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
    in_valid = 1'b0;
    drain();

    // back-pressure: 5 beats, out_ready low for 4 edges
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          ra = 8'(8'h30 + 8'(i * 17));
          rb = 8'(8'h0B + 8'(i * 5));
          ro = 2'(i);
          send(ro, ra, rb, 1'b1, model(ro, ra, rb, 1'b1));
        end
        in_valid = 1'b0;
      end
      begin
        tick(); tick();
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = sum;
        tick();
        check("bp_in_ready_low2", 32'(in_ready), 32'd0);
        check("bp_sum_hold", 32'(sum), 32'(held));
        tick();
        check("bp_sum_hold2", 32'(sum), 32'(held));
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_stream_valid", 32'(out_valid), 32'd1);
        end
      end
    join
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(2'b00, 8'h11, 8'h22, 1'b0, 11'h0);
    send(2'b00, 8'h33, 8'h44, 1'b0, 11'h0);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_no_stale", 32'(out_valid), 32'd0);
    send(2'b01, 8'h40, 8'h41, 1'b0, model(2'b01, 8'h40, 8'h41, 1'b0));
    in_valid = 1'b0;
    check("post_rst_lat0", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_lat1", 32'(out_valid), 32'd1);
    drain();

    // random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
          end
          ro = 2'($urandom_range(0, 3));
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rc = 1'($urandom_range(0, 1));
          send(ro, ra, rb, rc, model(ro, ra, rb, rc));
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 120; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
